float_add_pipe: RTL
===================

# float_add_pipe

Pipelined, parametrised IEEE-754 binary floating-point adder/subtractor for the FPU datapath. It generalises the combinational half-precision adder in three ways: arbitrary exponent and fraction widths, an add/subtract op select, and all five RISC-V rounding modes including RMM. It also produces accrued exception flags, uses a valid/ready handshake with backpressure, and has a fixed 3-cycle latency. It sits between the FPU issue logic and the FPU writeback/flag accumulation.

## Interface
Parameters:
- EXPONENT_WIDTH, default 5: exponent field width.
- FRACTION_WIDTH, default 10: stored fraction width.
- FLOAT_WIDTH, default 1+EXPONENT_WIDTH+FRACTION_WIDTH: operand width (derived; do not override).
- TAG_WIDTH, default 4: opaque tag carried alongside each operation.

Ports:
- CLK, input, 1: clock. One clock, all logic on the rising edge.
- RST, input, 1: reset. Synchronous, active-high.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: operation accepted this cycle when in_valid & in_ready.
- float1, input, FLOAT_WIDTH: operand A.
- float2, input, FLOAT_WIDTH: operand B.
- op_sub, input, 1: 0 computes A+B; 1 computes A−B (float2 sign inverted before processing).
- rounding_mode, input, fpu_rm_t: RM_RNE, RM_RTZ, RM_RDN, RM_RUP or RM_RMM; any other value is treated as RM_RNE.
- in_tag, input, TAG_WIDTH: passthrough tag.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer accepts the result when out_valid & out_ready.
- sum, output, FLOAT_WIDTH: rounded result.
- flags, output, 5: {NV, DZ, OF, UF, NX}. DZ is always 0.
- out_tag, output, TAG_WIDTH: tag of the result.

## Operation
- **S1, unpack/align:**
  - Classify each operand as zero, subnormal, normal, inf, qNaN or sNaN.
  - Swap so A has the larger magnitude (compare exponent, then fraction).
  - Compute the effective exponent of a subnormal as 1.
  - Right-shift B's significand by the exponent difference into an F+4-bit datapath: hidden bit, fraction, guard, round and sticky bits.
  - Shift amount saturates at FRACTION_WIDTH+3; all bits shifted out OR into sticky.
- **S2, add/normalise:**
  - Effective subtract = sign A XOR sign B.
  - On a carry-out, shift right 1, increment the exponent and preserve sticky.
  - On a subtract, a leading-zero count left-shifts by min(lzc, expA−1). The result becomes subnormal when that limit is reached.
  - No iterative loops; the shifter is a single combinational barrel shifter.
- **S3, round/pack:**
  - Round-up decision from LSB, G, R, S and the sign:
    - RNE: G&(R|S|LSB).
    - RMM: G.
    - RUP: ~sign&(G|R|S).
    - RDN: sign&(G|R|S).
    - RTZ: 0.
  - A rounding carry renormalises: the exponent is incremented, and a subnormal that rounds up becomes the minimum normal.
- **Special cases (priority order):**
  - Either sNaN, or inf−inf (effective) → canonical NaN (sign 0, exponent all-ones, fraction MSB only), NV=1.
  - Either qNaN → canonical NaN, no flags.
  - Either inf → that inf.
  - Exact zero result: +0, except −0 when rounding_mode=RM_RDN, or when both operands are −0 (effective).
- **Overflow** (rounded exponent ≥ all-ones):
  - RNE/RMM → ±inf.
  - RTZ → ±max finite.
  - RUP → +inf if positive, −max finite if negative.
  - RDN → −inf if negative, +max finite if positive.
  - OF=NX=1.
- **Flags:**
  - NX=1 when G|R|S is nonzero (before rounding) or on overflow.
  - UF=1 when the result is tiny before rounding and NX=1.

## Timing
- Three register stages (S1→S2→S3); sum, flags and out_tag are registered outputs.
- Latency: result valid exactly 3 cycles after acceptance when not stalled.
- Throughput: 1 operation per cycle.
- Global stall enable: adv = ~out_valid | out_ready. Every stage loads only when adv=1. in_ready = adv (combinational from out_valid/out_ready; no dependence on in_valid).
- While out_valid & ~out_ready, sum, flags and out_tag must hold stable and no stage changes.
- Bubbles propagate: stage valid bits shift with adv; invalid stages do not block acceptance.
- Reset: all stage valid bits 0, out_valid=0, sum=0, flags=0, out_tag=0.
- Reset mid-operation: all in-flight operations are discarded with no output. in_ready=1 the cycle after RST deasserts.
- Simultaneous acceptance of input and output retirement in one cycle is legal and loses nothing.

## Test plan
- Basic add, default widths, RNE: 0x3C00+0x3C00 → 0x4000 after 3 cycles, flags 0. With op_sub=1: 0x4000−0x3C00 → 0x3C00.
- Rounding modes on a tie: 0x3C00+0x1000 (1+2^-11). RNE → 0x3C00, NX. RMM → 0x3C01, NX. RUP → 0x3C01. RTZ → 0x3C00.
- Overflow and specials:
  - 0x7BFF+0x7BFF RNE → 0x7C00, flags OF|NX.
  - Same operands, RTZ → 0x7BFF.
  - 0x7C00+0xFC00 → 0x7E00, NV.
  - sNaN 0x7C01+0x3C00 → 0x7E00, NV.
- Subnormals and cancellation:
  - 0x0001+0x0001 → 0x0002.
  - 0x03FF+0x0001 → 0x0400.
  - 0x3C00−0x3C00 RNE → 0x0000; RDN → 0x8000.
- Backpressure: issue 6 back-to-back ops with tags 0–5 and out_ready=0 from cycle 2. Required: in_ready falls once the pipe fills, outputs are held stable, then drain in tag order 0–5 with none lost or duplicated.
- Reset mid-stream: assert RST with 3 ops in flight. Required: no out_valid afterwards; the first post-reset op completes in 3 cycles with a correct result.
- Parametrised build: EXPONENT_WIDTH=8, FRACTION_WIDTH=23; 0x3F800000+0x40000000 → 0x40400000.

Source files
------------

// File: rtl/float_add_pipe.sv
// Three-stage IEEE-754 adder/subtractor: unpack/align, add/normalise, round/pack.
// RISC-V rounding modes, accrued flags, one global stall enable for the whole pipe.
package fpu_pkg;
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } fpu_rm_t;
endpackage

module float_add_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH = 5,
    parameter int unsigned FRACTION_WIDTH = 10,
    parameter int unsigned FLOAT_WIDTH    = 1 + EXPONENT_WIDTH + FRACTION_WIDTH,
    parameter int unsigned TAG_WIDTH      = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] float1,
    input  logic [FLOAT_WIDTH-1:0] float2,
    input  logic                   op_sub,
    input  fpu_rm_t                rounding_mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] sum,
    output logic [4:0]             flags,
    output logic [TAG_WIDTH-1:0]   out_tag
);
    localparam int unsigned E = EXPONENT_WIDTH;
    localparam int unsigned F = FRACTION_WIDTH;
    localparam int unsigned M = F + 4;  // hidden, fraction, guard, round, sticky

    localparam logic [E-1:0]           EXP_ONES  = '1;
    localparam logic [FLOAT_WIDTH-1:0] CANON_NAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack / classify / swap / align ----------------
    logic         sign_1, sign_2, swap;
    logic [E-1:0] exp_1, exp_2, exp_a, exp_b, eff_exp_a, eff_exp_b, exp_diff;
    logic [F-1:0] frac_1, frac_2, frac_a, frac_b;
    logic         inf_1, inf_2, nan_1, nan_2, snan_1, snan_2, zero_1, zero_2;
    logic [M-1:0] sig_a, sig_b_full, sig_b_al;
    logic [2*M-1:0] b_wide;
    int unsigned  shift_b;
    logic         spec_c, spec_nv_c, zero_sign_c;
    logic [FLOAT_WIDTH-1:0] spec_val_c;
    fpu_rm_t      rm_c;

    assign sign_1 = float1[FLOAT_WIDTH-1];
    assign sign_2 = float2[FLOAT_WIDTH-1] ^ op_sub;
    assign exp_1  = float1[F +: E];
    assign exp_2  = float2[F +: E];
    assign frac_1 = float1[F-1:0];
    assign frac_2 = float2[F-1:0];

    assign inf_1  = (exp_1 == EXP_ONES) && (frac_1 == '0);
    assign inf_2  = (exp_2 == EXP_ONES) && (frac_2 == '0);
    assign nan_1  = (exp_1 == EXP_ONES) && (frac_1 != '0);
    assign nan_2  = (exp_2 == EXP_ONES) && (frac_2 != '0);
    assign snan_1 = nan_1 && !frac_1[F-1];
    assign snan_2 = nan_2 && !frac_2[F-1];
    assign zero_1 = (exp_1 == '0) && (frac_1 == '0);
    assign zero_2 = (exp_2 == '0) && (frac_2 == '0);

    assign swap      = {exp_2, frac_2} > {exp_1, frac_1};
    assign exp_a     = swap ? exp_2 : exp_1;
    assign exp_b     = swap ? exp_1 : exp_2;
    assign frac_a    = swap ? frac_2 : frac_1;
    assign frac_b    = swap ? frac_1 : frac_2;
    assign eff_exp_a = (exp_a == '0) ? E'(1) : exp_a;
    assign eff_exp_b = (exp_b == '0) ? E'(1) : exp_b;
    assign exp_diff  = eff_exp_a - eff_exp_b;

    assign sig_a      = {exp_a != '0, frac_a, 3'b000};
    assign sig_b_full = {exp_b != '0, frac_b, 3'b000};
    assign shift_b    = (32'(exp_diff) > M - 1) ? M - 1 : 32'(exp_diff);
    // Shift into a double-width field: the low half is everything lost to sticky.
    assign b_wide     = {sig_b_full, {M{1'b0}}} >> shift_b;
    assign sig_b_al   = b_wide[2*M-1:M] | {{(M-1){1'b0}}, |b_wide[M-1:0]};

    always_comb begin
        spec_c     = nan_1 | nan_2 | inf_1 | inf_2;
        spec_nv_c  = snan_1 | snan_2 | (inf_1 & inf_2 & (sign_1 ^ sign_2));
        spec_val_c = {(inf_1 ? sign_1 : sign_2), EXP_ONES, {F{1'b0}}};
        if (nan_1 | nan_2 | (inf_1 & inf_2 & (sign_1 ^ sign_2)))
            spec_val_c = CANON_NAN;
        case (rounding_mode)
            RM_RTZ, RM_RDN, RM_RUP, RM_RMM: rm_c = rounding_mode;
            default:                        rm_c = RM_RNE;
        endcase
        // Like-signed zeros keep their sign; any other exact zero depends on the mode.
        if (zero_1 && zero_2 && (sign_1 == sign_2))
            zero_sign_c = sign_1;
        else
            zero_sign_c = (rm_c == RM_RDN);
    end

    logic                   s1_valid, s1_sign, s1_sub, s1_spec, s1_spec_nv, s1_zero_sign;
    logic [E-1:0]           s1_exp;
    logic [M-1:0]           s1_sig_a, s1_sig_b;
    logic [FLOAT_WIDTH-1:0] s1_spec_val;
    fpu_rm_t                s1_rm;
    logic [TAG_WIDTH-1:0]   s1_tag;

    always_ff @(posedge CLK) begin
        if (adv) begin
            s1_sign      <= swap ? sign_2 : sign_1;
            s1_sub       <= sign_1 ^ sign_2;
            s1_exp       <= eff_exp_a;
            s1_sig_a     <= sig_a;
            s1_sig_b     <= sig_b_al;
            s1_spec      <= spec_c;
            s1_spec_nv   <= spec_nv_c;
            s1_spec_val  <= spec_val_c;
            s1_zero_sign <= zero_sign_c;
            s1_rm        <= rm_c;
            s1_tag       <= in_tag;
        end
    end

    // ---------------- S2: add / normalise ----------------
    logic [M:0]   add_raw;
    logic [M-1:0] sub_raw, mant_c;
    logic [E:0]   exp2_c;
    logic         zero_c;
    int unsigned  lzc, lim, norm_sh;

    assign add_raw = {1'b0, s1_sig_a} + {1'b0, s1_sig_b};
    assign sub_raw = s1_sig_a - s1_sig_b;

    always_comb begin
        lzc = M;
        for (int unsigned i = 0; i < M; i++)
            if (sub_raw[i]) lzc = M - 1 - i;
        lim     = 32'(s1_exp) - 1;
        norm_sh = (lzc < lim) ? lzc : lim;
        if (!s1_sub) begin
            zero_c = (add_raw == '0);
            if (add_raw[M]) begin
                mant_c = {add_raw[M:2], add_raw[1] | add_raw[0]};
                exp2_c = {1'b0, s1_exp} + (E+1)'(1);
            end else begin
                mant_c = add_raw[M-1:0];
                exp2_c = {1'b0, s1_exp};
            end
        end else begin
            zero_c = (sub_raw == '0);
            mant_c = sub_raw << norm_sh;
            exp2_c = {1'b0, s1_exp} - (E+1)'(norm_sh);
        end
    end

    logic                   s2_valid, s2_sign, s2_zero, s2_spec, s2_spec_nv, s2_zero_sign;
    logic [E:0]             s2_exp;
    logic [M-1:0]           s2_mant;
    logic [FLOAT_WIDTH-1:0] s2_spec_val;
    fpu_rm_t                s2_rm;
    logic [TAG_WIDTH-1:0]   s2_tag;

    always_ff @(posedge CLK) begin
        if (adv) begin
            s2_sign      <= s1_sign;
            s2_zero      <= zero_c;
            s2_exp       <= exp2_c;
            s2_mant      <= mant_c;
            s2_spec      <= s1_spec;
            s2_spec_nv   <= s1_spec_nv;
            s2_spec_val  <= s1_spec_val;
            s2_zero_sign <= s1_zero_sign;
            s2_rm        <= s1_rm;
            s2_tag       <= s1_tag;
        end
    end

    // ---------------- S3: round / pack / specials ----------------
    logic                   grs, round_up, hidden, ovf, tiny;
    logic [F+1:0]           rounded;
    logic [E:0]             r_exp;
    logic [F-1:0]           r_frac;
    logic [E-1:0]           pack_exp;
    logic [FLOAT_WIDTH-1:0] res_c, inf_c, maxf_c;
    logic [4:0]             flags_c;

    assign grs  = |s2_mant[2:0];
    assign tiny = ~s2_mant[M-1];

    always_comb begin
        case (s2_rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = s2_sign & grs;
            RM_RUP:  round_up = ~s2_sign & grs;
            RM_RMM:  round_up = s2_mant[2];
            default: round_up = s2_mant[2] & (s2_mant[1] | s2_mant[0] | s2_mant[3]);
        endcase
        rounded = {1'b0, s2_mant[M-1:3]} + (F+2)'(round_up);
        // A subnormal that rounds into the hidden bit is the minimum normal (exp stays 1).
        if (rounded[F+1]) begin
            r_exp  = s2_exp + (E+1)'(1);
            r_frac = rounded[F:1];
            hidden = 1'b1;
        end else begin
            r_exp  = s2_exp;
            r_frac = rounded[F-1:0];
            hidden = rounded[F];
        end
        pack_exp = hidden ? r_exp[E-1:0] : {E{1'b0}};
        ovf      = r_exp >= {1'b0, EXP_ONES};
        inf_c    = {s2_sign, EXP_ONES, {F{1'b0}}};
        maxf_c   = {s2_sign, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};

        res_c   = {s2_sign, pack_exp, r_frac};
        flags_c = {3'b000, tiny & grs, grs};
        if (s2_spec) begin
            res_c   = s2_spec_val;
            flags_c = {s2_spec_nv, 4'b0000};
        end else if (s2_zero) begin
            res_c   = {s2_zero_sign, {(FLOAT_WIDTH-1){1'b0}}};
            flags_c = '0;
        end else if (ovf) begin
            flags_c = 5'b00101;
            case (s2_rm)
                RM_RTZ:  res_c = maxf_c;
                RM_RUP:  res_c = s2_sign ? maxf_c : inf_c;
                RM_RDN:  res_c = s2_sign ? inf_c : maxf_c;
                default: res_c = inf_c;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            flags     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                sum     <= res_c;
                flags   <= flags_c;
                out_tag <= s2_tag;
            end
        end
    end
endmodule
